// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Purpose:
//   Instruction fetch stage. The block holds a 32-bit fetch PC and drives it
//   onto a combinational instruction ROM. The returned word is captured, with
//   its PC, into a two-entry FIFO. The decode stage drains the FIFO through a
//   valid/ready handshake. A redirect flushes the FIFO and restarts fetch at a
//   new target. Because instr and instr_pc come only from registers, rom_data
//   has no combinational path to the decode side.
//
// Parameters:
//   MemSize       byte size of the instruction ROM (addresses alias modulo it)
//   ResetPc       first fetch address after reset
//   MemAddrWidth  derived ROM address width, $clog2(MemSize)
//
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   rom_address  out  byte address into the instruction ROM
//   rom_data     in   ROM word at rom_address, same cycle
//   instr        out  instruction at the FIFO head
//   instr_pc     out  byte PC of instr
//   instr_valid  out  FIFO head holds a valid instruction
//   instr_ready  in   decode accepts the head this cycle
//   redirect     in   flush and restart fetch at redirect_pc
//   redirect_pc  in   redirect target byte PC
//   fetch_fault  out  sticky misaligned-redirect flag
//
// Configuration macro:
//   FETCH_MISALIGN_CHECK_EN  when defined, a redirect to a PC whose low two
//                            bits are non-zero sets fetch_fault, which holds
//                            until reset. When undefined, fetch_fault is tied
//                            low. In both builds the target is word-aligned
//                            by forcing the low two bits to zero.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned MemSize      = 'h0000_1000,
  parameter logic [31:0] ResetPc      = 32'h0000_0000,
  localparam int unsigned MemAddrWidth = $clog2(MemSize)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic [MemAddrWidth-1:0] rom_address,
  input  logic [31:0]             rom_data,
  output logic [31:0]             instr,
  output logic [31:0]             instr_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  output logic                    fetch_fault
);

  // FIFO occupancy: no entries, one entry, or two entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

  fifo_state_t state;
  fifo_state_t state_next;

  logic [31:0] fetch_pc;
  logic [31:0] redirect_target;

  // Head entry (presented to decode) and tail entry (second slot).
  logic [31:0] head_instr;
  logic [31:0] head_pc;
  logic [31:0] tail_instr;
  logic [31:0] tail_pc;

  logic push;
  logic pop;

  // The ROM sees the low fetch_pc bits, so out-of-range PCs alias.
  assign rom_address = fetch_pc[MemAddrWidth-1:0];

  // A redirect always lands on a word boundary.
  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // A redirect in the current cycle hides the head, even though the FIFO is
  // only flushed at the coming edge.
  assign instr_valid = (state != EMPTY) && !redirect;
  assign instr       = head_instr;
  assign instr_pc    = head_pc;

  // FIFO state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Handshake decode and occupancy next-state. A full FIFO can still accept
  // a new word in the same cycle that its head is popped, which gives
  // back-to-back throughput.
  always_comb begin
    state_next = state;
    pop        = instr_valid && instr_ready && !redirect;
    push       = !redirect && ((state != FULL) || pop);

    if (redirect) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_next = ONE;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_next = FULL;
          end else if (pop && !push) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (pop && !push) begin
            state_next = ONE;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  // Fetch PC. It advances on every push and wraps naturally at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= ResetPc;
    end else if (redirect) begin
      fetch_pc <= redirect_target;
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // FIFO storage. A new word goes into whichever slot is the tail for the
  // current occupancy. When a pop and a push happen together, the surviving
  // entry shifts toward the head. Entries are left untouched on a redirect,
  // because occupancy alone decides what is visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_instr <= 32'd0;
      head_pc    <= 32'd0;
      tail_instr <= 32'd0;
      tail_pc    <= 32'd0;
    end else if (!redirect) begin
      case (state)
        EMPTY: begin
          if (push) begin
            head_instr <= rom_data;
            head_pc    <= fetch_pc;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_instr <= rom_data;
            head_pc    <= fetch_pc;
          end else if (push) begin
            tail_instr <= rom_data;
            tail_pc    <= fetch_pc;
          end
        end
        FULL: begin
          if (pop) begin
            head_instr <= tail_instr;
            head_pc    <= tail_pc;
            if (push) begin
              tail_instr <= rom_data;
              tail_pc    <= fetch_pc;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Sticky flag. Once a misaligned redirect is seen, only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_fault <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      fetch_fault <= 1'b1;
    end
  end
`else
  // Alignment is silently enforced, so the low target bits carry no meaning.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign fetch_fault          = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Purpose:
//   Directed self-checking bench for instr_fetch. A 4 KiB combinational ROM
//   model feeds the DUT. Expected values are worked out by hand from the ROM
//   contents and the FIFO timing.
//
// Ports: none (top-level bench).
// Configuration macro: FETCH_MISALIGN_CHECK_EN selects the expected
// fetch_fault value after a misaligned redirect.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int unsigned MemSize = 'h1000;
  localparam int unsigned AddrW   = 12;

  logic             clk;
  logic             reset_n;
  logic [AddrW-1:0] rom_address;
  logic [31:0]      rom_data;
  logic [31:0]      instr;
  logic [31:0]      instr_pc;
  logic             instr_valid;
  logic             instr_ready;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             fetch_fault;

  logic [31:0] mem [0:1023];

  int checks;
  int failures;
  logic exp_fault;

  instr_fetch #(
    .MemSize(MemSize),
    .ResetPc(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rom_address(rom_address),
    .rom_data(rom_data),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault)
  );

  // Combinational ROM: the word addressed by the byte address.
  assign rom_data = mem[rom_address[AddrW-1:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time bound so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic redir,
                               input logic [31:0] rpc);
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
  endtask

  // Advance past the next rising edge and leave time for outputs to settle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
    exp_fault = 1'b1;
`else
    exp_fault = 1'b0;
`endif
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'hA000_0000 | i;
    end
    mem[0] = 32'h5000_0117;
    mem[1] = 32'h5001_0113;
    mem[2] = 32'h3501_5073;
    mem[3] = 32'h3004_5073;

    // Reset values, sampled while reset is held low.
    reset_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_pc", instr_pc, 32'd0);
    checkOutput("rst_fault", {31'd0, fetch_fault}, 32'd0);
    checkOutput("rst_addr", {20'd0, rom_address}, 32'd0);

    // Streaming: one instruction accepted per cycle after the first.
    reset_n = 1'b1;
    #1;
    checkOutput("rel_valid0", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("str_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("str_pc", instr_pc, 32'(i * 4));
      checkOutput("str_instr", instr, mem[i]);
    end

    // Backpressure: the FIFO fills and fetch stalls at PC 8.
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    checkOutput("bp_pc", instr_pc, 32'h0);
    checkOutput("bp_fetch", {20'd0, rom_address}, 32'h8);
    applyStimulus(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_drain_pc", instr_pc, 32'(i * 4));
      checkOutput("bp_drain_instr", instr, mem[i]);
      tick();
    end

    // Redirect while full: two invisible cycles, then the target appears.
    applyStimulus(1'b0, 1'b1, 32'h34);
    checkOutput("rd_valid_n", {31'd0, instr_valid}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("rd_valid_n1", {31'd0, instr_valid}, 32'd0);
    checkOutput("rd_fetch", {20'd0, rom_address}, 32'h34);
    tick();
    checkOutput("rd_valid_n2", {31'd0, instr_valid}, 32'd1);
    checkOutput("rd_pc", instr_pc, 32'h34);
    checkOutput("rd_instr", instr, mem['h34 >> 2]);

    // Misaligned redirect target is word-aligned; fault depends on build.
    applyStimulus(1'b0, 1'b1, 32'h36);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("mis_pc", instr_pc, 32'h34);
    checkOutput("mis_fault", {31'd0, fetch_fault}, {31'd0, exp_fault});

    // Back-to-back redirects: FIFO stays empty, the last target wins.
    applyStimulus(1'b0, 1'b1, 32'h40);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h80);
    checkOutput("rr_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("rr_valid2", {31'd0, instr_valid}, 32'd0);
    tick();
    checkOutput("rr_pc", instr_pc, 32'h80);
    checkOutput("rr_instr", instr, mem['h80 >> 2]);
    checkOutput("sticky_fault", {31'd0, fetch_fault}, {31'd0, exp_fault});

    // Address aliasing: PC 0x1000 reads ROM word 0.
    applyStimulus(1'b0, 1'b1, 32'h1000);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("alias_addr", {20'd0, rom_address}, 32'h0);
    tick();
    checkOutput("alias_pc", instr_pc, 32'h1000);
    checkOutput("alias_instr", instr, mem[0]);

    // Fetch PC wraps from 0xFFFFFFFC to 0.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_instr", instr, mem[1023]);
    checkOutput("wrap_fetch", {20'd0, rom_address}, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("wrap_pc2", instr_pc, 32'h0);
    checkOutput("wrap_instr2", instr, mem[0]);

    // Asynchronous reset mid-stream, asserted between clock edges.
    tick();
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("ar_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("ar_pc", instr_pc, 32'd0);
    checkOutput("ar_fault", {31'd0, fetch_fault}, 32'd0);
    checkOutput("ar_addr", {20'd0, rom_address}, 32'd0);
    #1;
    reset_n = 1'b1;
    tick();
    checkOutput("ar_restart_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("ar_restart_pc", instr_pc, 32'd0);
    checkOutput("ar_restart_instr", instr, mem[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
